// File: rtl/main_fsm_mc_if.sv
// Handshake bundle between the multicycle control FSM and the memory /
// mul-div units. The FSM is the master: it raises the valids and waits for
// the readies.
interface main_fsm_mc_if;
    logic mem_valid;
    logic mem_ready;
    logic muldiv_valid;
    logic muldiv_ready;

    modport master (
        output mem_valid,
        output muldiv_valid,
        input  mem_ready,
        input  muldiv_ready
    );

    modport slave (
        input  mem_valid,
        input  muldiv_valid,
        output mem_ready,
        output muldiv_ready
    );
endinterface

// File: rtl/main_fsm_mc.sv
// Main control FSM of a multicycle RV32 core. One instruction walks through
// FETCH, DECODE and an opcode-dependent execute/writeback path; illegal
// opcodes and memory watchdog expiry park the machine in TRAP until reset.
module main_fsm_mc #(
    parameter int HAS_MULDIV  = 1,
    parameter int HAS_CSR     = 1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [6:0]    op,
    input  logic          funct7b1,
    main_fsm_mc_if.master bus,
    output logic [1:0]    AluSrcA,
    output logic [1:0]    AluSrcB,
    output logic [2:0]    AluOp,
    output logic [2:0]    ResultSrc,
    output logic [2:0]    ImmSrc,
    output logic          AdrSrc,
    output logic          IRWrite,
    output logic          PCUpdate,
    output logic          Branch,
    output logic          RegWrite,
    output logic          MemWrite,
    output logic          retire,
    output logic          illegal_instr,
    output logic          bus_error,
    output logic [4:0]    state
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRCA_RD1   = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RD2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_BRANCH = 3'd1;
    localparam logic [2:0] ALU_ARITH  = 3'd2;
    localparam logic [2:0] ALU_LUI    = 3'd3;
    localparam logic [2:0] ALU_AUIPC  = 3'd4;

    localparam logic [2:0] RES_ALUOUT    = 3'd0;
    localparam logic [2:0] RES_READDATA  = 3'd1;
    localparam logic [2:0] RES_ALURESULT = 3'd2;
    localparam logic [2:0] RES_CSRDATA   = 3'd3;
    localparam logic [2:0] RES_MULDIV    = 3'd4;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    // Last counter value before the watchdog fires; only meaningful when enabled.
    localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic       WD_EN   = (MEM_TIMEOUT != 0);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADR   = 5'd2,
        S_MEMREAD  = 5'd3,
        S_MEMWB    = 5'd4,
        S_MEMWRITE = 5'd5,
        S_EXEC_R   = 5'd6,
        S_EXEC_I   = 5'd7,
        S_LUI      = 5'd8,
        S_AUIPC    = 5'd9,
        S_ALUWB    = 5'd10,
        S_JALR     = 5'd11,
        S_JUMP     = 5'd12,
        S_BRANCH   = 5'd13,
        S_MULDIV   = 5'd14,
        S_SYSTEM   = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wd_cnt;
    logic       wd_trip;
    logic       mem_req;
    logic       trap_illegal;
    logic       trap_bus;
    logic       illegal_q;
    logic       bus_err_q;

    // Watchdog fires on the last permitted wait cycle; a same-cycle ready wins.
    assign wd_trip = WD_EN && (wd_cnt == WD_LAST) && !bus.mem_ready;

    assign bus.mem_valid = mem_req;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign state         = state_q;

    // State register, watchdog counter and sticky trap cause flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wd_cnt    <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (trap_illegal) begin
                illegal_q <= 1'b1;
            end
            if (trap_bus) begin
                bus_err_q <= 1'b1;
            end
            if (state_d != state_q) begin
                wd_cnt <= 8'd0;
            end else if (WD_EN && mem_req && !bus.mem_ready) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        ImmSrc = IMM_R;
        case (op)
            OP_RTYPE:                             ImmSrc = IMM_R;
            OP_ITYPE, OP_JALR, OP_LOAD, OP_SYSTEM: ImmSrc = IMM_I;
            OP_STORE:                             ImmSrc = IMM_S;
            OP_BRANCH:                            ImmSrc = IMM_B;
            OP_LUI, OP_AUIPC:                     ImmSrc = IMM_U;
            OP_JAL:                               ImmSrc = IMM_J;
            default:                              ImmSrc = IMM_R;
        endcase
    end

    // Next-state and control decode; everything stays at 0 while rst is high.
    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        bus.muldiv_valid = 1'b0;
        AluSrcA          = SRCA_RD1;
        AluSrcB          = SRCB_RD2;
        AluOp            = ALU_ADD;
        ResultSrc        = RES_ALUOUT;
        AdrSrc           = 1'b0;
        IRWrite          = 1'b0;
        PCUpdate         = 1'b0;
        Branch           = 1'b0;
        RegWrite         = 1'b0;
        MemWrite         = 1'b0;
        retire           = 1'b0;
        trap_illegal     = 1'b0;
        trap_bus         = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    AluSrcA   = SRCA_PC;
                    AluSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                    if (bus.mem_ready) begin
                        IRWrite  = 1'b1;
                        PCUpdate = 1'b1;
                        state_d  = S_DECODE;
                    end else if (wd_trip) begin
                        trap_bus = 1'b1;
                        state_d  = S_TRAP;
                    end
                end
                S_DECODE: begin
                    AluSrcA = SRCA_OLDPC;
                    AluSrcB = SRCB_IMM;
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE: begin
                            if (!funct7b1) begin
                                state_d = S_EXEC_R;
                            end else if (HAS_MULDIV != 0) begin
                                state_d = S_MULDIV;
                            end else begin
                                trap_illegal = 1'b1;
                                state_d      = S_TRAP;
                            end
                        end
                        OP_ITYPE:  state_d = S_EXEC_I;
                        OP_JAL:    state_d = S_JUMP;
                        OP_JALR:   state_d = S_JALR;
                        OP_BRANCH: state_d = S_BRANCH;
                        OP_LUI:    state_d = S_LUI;
                        OP_AUIPC:  state_d = S_AUIPC;
                        OP_SYSTEM: begin
                            if (HAS_CSR != 0) begin
                                state_d = S_SYSTEM;
                            end else begin
                                trap_illegal = 1'b1;
                                state_d      = S_TRAP;
                            end
                        end
                        default: begin
                            trap_illegal = 1'b1;
                            state_d      = S_TRAP;
                        end
                    endcase
                end
                S_MEMADR: begin
                    AluSrcB = SRCB_IMM;
                    state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (wd_trip) begin
                        trap_bus = 1'b1;
                        state_d  = S_TRAP;
                    end
                end
                S_MEMWB: begin
                    ResultSrc = RES_READDATA;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    if (bus.mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (wd_trip) begin
                        trap_bus = 1'b1;
                        state_d  = S_TRAP;
                    end
                end
                S_EXEC_R: begin
                    AluOp   = ALU_ARITH;
                    state_d = S_ALUWB;
                end
                S_EXEC_I: begin
                    AluSrcB = SRCB_IMM;
                    AluOp   = ALU_ARITH;
                    state_d = S_ALUWB;
                end
                S_LUI: begin
                    AluSrcB = SRCB_IMM;
                    AluOp   = ALU_LUI;
                    state_d = S_ALUWB;
                end
                S_AUIPC: begin
                    AluSrcA = SRCA_OLDPC;
                    AluSrcB = SRCB_IMM;
                    AluOp   = ALU_AUIPC;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JALR: begin
                    AluSrcB = SRCB_IMM;
                    state_d = S_JUMP;
                end
                S_JUMP: begin
                    PCUpdate = 1'b1;
                    AluSrcA  = SRCA_OLDPC;
                    AluSrcB  = SRCB_FOUR;
                    state_d  = S_ALUWB;
                end
                S_BRANCH: begin
                    AluOp   = ALU_BRANCH;
                    Branch  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_MULDIV: begin
                    bus.muldiv_valid = 1'b1;
                    if (bus.muldiv_ready) begin
                        ResultSrc = RES_MULDIV;
                        RegWrite  = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_SYSTEM: begin
                    ResultSrc = RES_CSRDATA;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_fsm_mc.sv
// Bench for main_fsm_mc: two instances (full-featured, and reduced with a
// 4-cycle memory watchdog) run in lockstep on shared stimulus and are compared
// every cycle against an instruction-route reference model.
module tb_main_fsm_mc;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMREAD = 3;
    localparam int PH_MEMWB = 4, PH_MEMWRITE = 5, PH_EXEC_R = 6, PH_EXEC_I = 7;
    localparam int PH_LUI = 8, PH_AUIPC = 9, PH_ALUWB = 10, PH_JALR = 11;
    localparam int PH_JUMP = 12, PH_BRANCH = 13, PH_MULDIV = 14, PH_SYSTEM = 15;
    localparam int PH_TRAP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       funct7b1;
    logic       mem_rdy;
    logic       md_rdy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    main_fsm_mc_if if0 ();
    main_fsm_mc_if if1 ();
    assign if0.mem_ready    = mem_rdy;
    assign if0.muldiv_ready = md_rdy;
    assign if1.mem_ready    = mem_rdy;
    assign if1.muldiv_ready = md_rdy;

    logic [1:0] a0, b0, a1, b1;
    logic [2:0] aop0, rs0, imm0, aop1, rs1, imm1;
    logic       ad0, irw0, pcu0, br0, rw0, mw0, ret0, ill0, be0;
    logic       ad1, irw1, pcu1, br1, rw1, mw1, ret1, ill1, be1;
    logic [4:0] st0, st1;

    main_fsm_mc #(.HAS_MULDIV(1), .HAS_CSR(1), .MEM_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .funct7b1(funct7b1), .bus(if0),
        .AluSrcA(a0), .AluSrcB(b0), .AluOp(aop0), .ResultSrc(rs0), .ImmSrc(imm0),
        .AdrSrc(ad0), .IRWrite(irw0), .PCUpdate(pcu0), .Branch(br0), .RegWrite(rw0),
        .MemWrite(mw0), .retire(ret0), .illegal_instr(ill0), .bus_error(be0), .state(st0)
    );

    main_fsm_mc #(.HAS_MULDIV(0), .HAS_CSR(0), .MEM_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .op(op), .funct7b1(funct7b1), .bus(if1),
        .AluSrcA(a1), .AluSrcB(b1), .AluOp(aop1), .ResultSrc(rs1), .ImmSrc(imm1),
        .AdrSrc(ad1), .IRWrite(irw1), .PCUpdate(pcu1), .Branch(br1), .RegWrite(rw1),
        .MemWrite(mw1), .retire(ret1), .illegal_instr(ill1), .bus_error(be1), .state(st1)
    );

    // Bit map: [23] mem_valid [22] muldiv_valid [21:20] AluSrcA [19:18] AluSrcB
    // [17:15] AluOp [14:12] ResultSrc [11:9] ImmSrc [8] AdrSrc [7] IRWrite
    // [6] PCUpdate [5] Branch [4] RegWrite [3] MemWrite [2] retire
    // [1] illegal_instr [0] bus_error
    logic [23:0] obs0, obs1, last0, last1;
    assign obs0 = {if0.mem_valid, if0.muldiv_valid, a0, b0, aop0, rs0, imm0,
                   ad0, irw0, pcu0, br0, rw0, mw0, ret0, ill0, be0};
    assign obs1 = {if1.mem_valid, if1.muldiv_valid, a1, b1, aop1, rs1, imm1,
                   ad1, irw1, pcu1, br1, rw1, mw1, ret1, ill1, be1};

    // Reference model: per instance, current phase, the remaining route of the
    // decoded instruction, wait cycles spent in the current access, and flags.
    int   has_md[2]  = '{1, 0};
    int   has_csr[2] = '{1, 0};
    int   tmo[2]     = '{0, 4};
    int   ph[2];
    int   wt[2];
    int   rq[2][4];
    int   rlen[2];
    int   rpos[2];
    logic ill[2];
    logic be[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            OP_ITYPE, OP_JALR, OP_LOAD, OP_SYSTEM: return 3'd1;
            OP_STORE:                             return 3'd2;
            OP_BRANCH:                            return 3'd3;
            OP_LUI, OP_AUIPC:                     return 3'd4;
            OP_JAL:                               return 3'd5;
            default:                              return 3'd0;
        endcase
    endfunction

    function automatic logic [23:0] exp_vec(input int p, input logic r, input logic mr,
                                            input logic dr, input logic [6:0] o,
                                            input logic il, input logic bf);
        logic mv, dv, ad, irw, pcu, br, rw, mw, ret;
        logic [1:0] a, b;
        logic [2:0] aop, rs;
        mv = 0; dv = 0; ad = 0; irw = 0; pcu = 0; br = 0; rw = 0; mw = 0; ret = 0;
        a = 0; b = 0; aop = 0; rs = 0;
        if (!r) begin
            case (p)
                PH_FETCH:    begin mv = 1; a = 1; b = 2; rs = 2; irw = mr; pcu = mr; end
                PH_DECODE:   begin a = 2; b = 1; end
                PH_MEMADR:   begin b = 1; end
                PH_MEMREAD:  begin mv = 1; ad = 1; end
                PH_MEMWB:    begin rs = 1; rw = 1; ret = 1; end
                PH_MEMWRITE: begin mv = 1; ad = 1; mw = 1; ret = mr; end
                PH_EXEC_R:   begin aop = 2; end
                PH_EXEC_I:   begin b = 1; aop = 2; end
                PH_LUI:      begin b = 1; aop = 3; end
                PH_AUIPC:    begin a = 2; b = 1; aop = 4; end
                PH_ALUWB:    begin rw = 1; ret = 1; end
                PH_JALR:     begin b = 1; end
                PH_JUMP:     begin pcu = 1; a = 2; b = 2; end
                PH_BRANCH:   begin aop = 1; br = 1; ret = 1; end
                PH_MULDIV:   begin dv = 1; if (dr) begin rs = 4; rw = 1; ret = 1; end end
                PH_SYSTEM:   begin rs = 3; rw = 1; ret = 1; end
                default:     begin end
            endcase
        end
        return {mv, dv, a, b, aop, rs, imm_of(o), ad, irw, pcu, br, rw, mw, ret, il, bf};
    endfunction

    task automatic push(input int k, input int p);
        rq[k][rlen[k]] = p;
        rlen[k]++;
    endtask

    task automatic pop_route(input int k, output int p);
        if (rpos[k] < rlen[k]) begin
            p = rq[k][rpos[k]];
            rpos[k]++;
        end else begin
            p = PH_FETCH;
        end
    endtask

    // The whole post-decode path of an instruction, derived from its opcode.
    task automatic build_route(input int k, output bit ok);
        ok = 1'b1;
        rlen[k] = 0;
        rpos[k] = 0;
        case (op)
            OP_LOAD:   begin push(k, PH_MEMADR); push(k, PH_MEMREAD); push(k, PH_MEMWB); end
            OP_STORE:  begin push(k, PH_MEMADR); push(k, PH_MEMWRITE); end
            OP_RTYPE: begin
                if (!funct7b1) begin push(k, PH_EXEC_R); push(k, PH_ALUWB); end
                else if (has_md[k] != 0) push(k, PH_MULDIV);
                else ok = 1'b0;
            end
            OP_ITYPE:  begin push(k, PH_EXEC_I); push(k, PH_ALUWB); end
            OP_JAL:    begin push(k, PH_JUMP); push(k, PH_ALUWB); end
            OP_JALR:   begin push(k, PH_JALR); push(k, PH_JUMP); push(k, PH_ALUWB); end
            OP_BRANCH: push(k, PH_BRANCH);
            OP_LUI:    begin push(k, PH_LUI); push(k, PH_ALUWB); end
            OP_AUIPC:  begin push(k, PH_AUIPC); push(k, PH_ALUWB); end
            OP_SYSTEM: begin
                if (has_csr[k] != 0) push(k, PH_SYSTEM);
                else ok = 1'b0;
            end
            default:   ok = 1'b0;
        endcase
    endtask

    task automatic model_step(input int k);
        int  nph;
        bit  ok;
        bit  mem_phase;
        if (rst) begin
            ph[k] = PH_FETCH; wt[k] = 0; ill[k] = 0; be[k] = 0; rlen[k] = 0; rpos[k] = 0;
        end else begin
            nph = ph[k];
            mem_phase = (ph[k] == PH_FETCH) || (ph[k] == PH_MEMREAD) || (ph[k] == PH_MEMWRITE);
            case (ph[k])
                PH_FETCH, PH_MEMREAD, PH_MEMWRITE: begin
                    if (mem_rdy) begin
                        if (ph[k] == PH_FETCH) nph = PH_DECODE;
                        else pop_route(k, nph);
                    end else if (tmo[k] > 0 && wt[k] == tmo[k] - 1) begin
                        nph = PH_TRAP;
                        be[k] = 1'b1;
                    end
                end
                PH_DECODE: begin
                    build_route(k, ok);
                    if (ok) pop_route(k, nph);
                    else begin nph = PH_TRAP; ill[k] = 1'b1; end
                end
                PH_MULDIV: if (md_rdy) pop_route(k, nph);
                PH_TRAP:   nph = PH_TRAP;
                default:   pop_route(k, nph);
            endcase
            if (nph != ph[k]) wt[k] = 0;
            else if (mem_phase && !mem_rdy) wt[k]++;
            ph[k] = nph;
        end
    endtask

    // Check both instances mid-cycle, then advance the model at the edge.
    task automatic cycle();
        #1;
        chk($sformatf("dut0_cycle%0d", cyc), {8'b0, obs0},
            {8'b0, exp_vec(ph[0], rst, mem_rdy, md_rdy, op, ill[0], be[0])});
        chk($sformatf("dut1_cycle%0d", cyc), {8'b0, obs1},
            {8'b0, exp_vec(ph[1], rst, mem_rdy, md_rdy, op, ill[1], be[1])});
        last0 = obs0;
        last1 = obs1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        @(negedge clk);
    endtask

    logic [6:0] ops[12];
    logic [3:0] pat_a, pat_b;
    int         cnt;
    logic       seen;

    initial begin
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_JALR, OP_BRANCH,
                OP_LUI, OP_AUIPC, OP_SYSTEM, 7'b0000000, 7'b1111111};
        for (int k = 0; k < 2; k++) begin
            ph[k] = PH_FETCH; wt[k] = 0; ill[k] = 0; be[k] = 0; rlen[k] = 0; rpos[k] = 0;
        end
        rst = 1'b1; op = OP_ITYPE; funct7b1 = 1'b0; mem_rdy = 1'b1; md_rdy = 1'b0;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);

        // Reset held: every strobe low, flags clear.
        cycle();
        chk("rst_mem_valid", {31'b0, last0[23]}, 32'd0);
        rst = 1'b0;

        // addi with memory always ready: retire and RegWrite only on cycle 4.
        pat_a = 0; pat_b = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pat_a = {pat_a[2:0], last0[2]};
            pat_b = {pat_b[2:0], last0[4]};
        end
        chk("addi_retire_pattern", {28'b0, pat_a}, 32'b0001);
        chk("addi_regwrite_pattern", {28'b0, pat_b}, 32'b0001);

        // lw with two wait cycles in MEMREAD.
        op = OP_LOAD; cnt = 0;
        for (int i = 0; i < 7; i++) begin
            mem_rdy = !(i == 3 || i == 4);
            cycle();
            if (last0[23] && last0[8]) cnt++;
        end
        chk("lw_memread_cycles", cnt, 3);
        chk("lw_writeback_resultsrc", {29'b0, last0[14:12]}, 32'd1);
        chk("lw_writeback_retire", {31'b0, last0[2]}, 32'd1);

        // jal: PCUpdate in FETCH and JUMP, retire on cycle 4.
        op = OP_JAL; mem_rdy = 1'b1; pat_a = 0; pat_b = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            pat_a = {pat_a[2:0], last0[6]};
            pat_b = {pat_b[2:0], last0[2]};
        end
        chk("jal_pcupdate_pattern", {28'b0, pat_a}, 32'b1010);
        chk("jal_retire_pattern", {28'b0, pat_b}, 32'b0001);

        // mul: unit answers on its 5th cycle; reduced instance traps instead.
        op = OP_RTYPE; funct7b1 = 1'b1; cnt = 0;
        for (int i = 0; i < 7; i++) begin
            md_rdy = (i == 6);
            cycle();
            if (last0[22]) cnt++;
        end
        chk("mul_muldiv_valid_cycles", cnt, 5);
        chk("mul_writeback_resultsrc", {29'b0, last0[14:12]}, 32'd4);
        chk("nomul_illegal_flag", {30'b0, last1[1:0]}, 32'b10);
        md_rdy = 1'b0; funct7b1 = 1'b0;

        // One-cycle reset out of TRAP, request on the following cycle.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_flags", {30'b0, last1[1:0]}, 32'd0);
        chk("post_rst_mem_valid", {31'b0, last1[23]}, 32'd1);

        // Opcode 0000000 is illegal on both.
        op = 7'b0000000;
        cycle();
        cycle();
        cycle();
        chk("op0_illegal", {30'b0, last0[1:0]}, 32'b10);
        chk("op0_trap_idle", {31'b0, last0[23]}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Watchdog: four unanswered fetch cycles trap the reduced instance.
        op = OP_ITYPE; mem_rdy = 1'b0; seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            seen = seen | last1[7];
        end
        chk("wd_bus_error", {30'b0, last1[1:0]}, 32'b01);
        chk("wd_no_irwrite", {31'b0, seen}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Ready arriving on the 4th wait cycle beats the watchdog.
        for (int i = 0; i < 4; i++) begin
            mem_rdy = (i == 3);
            cycle();
        end
        chk("wd_ready_irwrite", {31'b0, last1[7]}, 32'd1);
        cycle();
        chk("wd_ready_no_trap", {30'b0, last1[1:0]}, 32'd0);
        cycle();
        cycle();

        // Randomized traffic; opcode only changes between instructions.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            if ((ph[0] == PH_FETCH || ph[0] == PH_TRAP) &&
                (ph[1] == PH_FETCH || ph[1] == PH_TRAP)) begin
                op = ops[$urandom_range(0, 11)];
                funct7b1 = 1'($urandom_range(0, 1));
            end
            mem_rdy = ($urandom_range(0, 3) != 0);
            md_rdy  = ($urandom_range(0, 2) == 0);
            cycle();
        end
        chk("state0_defined", {31'b0, $isunknown(st0)}, 32'd0);
        chk("state1_defined", {31'b0, $isunknown(st1)}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
